// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns curPC, fetches words over req/ack into a 2-entry {pc, inst, err} FIFO.
// Optional feature: FETCH_ALIGN_CHECK_EN turns misaligned redirects into a single error entry instead of a fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] nextPC,
  input  logic        redirect,
  output logic [31:0] curPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        inst_ready,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: imem_req/imem_addr hold until a cycle with imem_ack=1 completes the request;
  // decode takes the FIFO head in any cycle where inst_valid=1 and inst_ready=1.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d, cnt_nx;
  logic [31:0] fpc_q   [2];
  logic [31:0] finst_q [2];
  logic        pop, push, wr_idx, err_push, misalign, parked;
  logic [31:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic park_q, park_d;
  logic ferr_q [2];
  assign tgt      = nextPC;
  assign misalign = (nextPC[1:0] != 2'b00);
  assign parked   = park_q;
`else
  assign tgt      = nextPC & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
  assign parked   = 1'b0;
`endif

  assign imem_req  = (state_q != ST_IDLE);
  assign pop       = (cnt_q != 2'd0) && inst_ready;
  assign push      = (state_q == ST_REQ) && imem_ack;
  // Occupancy after this cycle's pop and push; a request may be in flight only while this is below 2.
  assign cnt_nx    = cnt_q + {1'b0, push} - {1'b0, pop};
  assign wr_idx    = ((cnt_q - {1'b0, pop}) != 2'd0);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    cnt_d    = cnt_nx;
    err_push = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    park_d   = park_q;
`endif
    if (redirect) begin
      pc_d  = tgt;
      cnt_d = 2'd0;
      if (misalign) begin
        err_push = 1'b1;
        cnt_d    = 2'd1;
        state_d  = (imem_req && !imem_ack) ? ST_DROP : ST_IDLE;
      end else if (imem_req && !imem_ack) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_REQ;
        addr_d  = tgt;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      park_d = misalign;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!parked && cnt_nx < 2'd2) begin
            state_d = ST_REQ;
            addr_d  = pc_q;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            pc_d = pc_q + 32'd4;
            if (cnt_nx < 2'd2) addr_d = pc_q + 32'd4;
            else               state_d = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            if (parked) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_REQ;
              addr_d  = pc_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      cnt_q      <= 2'd0;
      fpc_q[0]   <= '0;
      fpc_q[1]   <= '0;
      finst_q[0] <= '0;
      finst_q[1] <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      park_q     <= 1'b0;
      ferr_q[0]  <= 1'b0;
      ferr_q[1]  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
`ifdef FETCH_ALIGN_CHECK_EN
      park_q  <= park_d;
`endif
      if (redirect) begin
        if (err_push) begin
          fpc_q[0]   <= nextPC;
          finst_q[0] <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
          ferr_q[0]  <= 1'b1;
`endif
        end
      end else begin
        if (pop) begin
          fpc_q[0]   <= fpc_q[1];
          finst_q[0] <= finst_q[1];
`ifdef FETCH_ALIGN_CHECK_EN
          ferr_q[0]  <= ferr_q[1];
`endif
        end
        // Written after the shift so a same-cycle push lands in the slot the pop just freed.
        if (push) begin
          fpc_q[wr_idx]   <= addr_q;
          finst_q[wr_idx] <= imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
          ferr_q[wr_idx]  <= 1'b0;
`endif
        end
      end
    end
  end

  assign curPC       = pc_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = (cnt_q != 2'd0);
  assign inst        = inst_valid ? finst_q[0] : '0;
  assign inst_pc     = inst_valid ? fpc_q[0] : '0;
  assign dbg_state_o = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign inst_err    = inst_valid & ferr_q[0];
`else
  assign inst_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ack/ready/redirect traffic checked
// against a queue-based behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] nextPC = '0;
  logic        redirect = 1'b0;
  logic [31:0] curPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_ready = 1'b0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Behavioural model: FIFO contents as {pc, inst}, next fetch PC, visible request, drop-pending flag.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc, m_addr;
  bit          m_req, m_discard;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset(Reset), .nextPC(nextPC), .redirect(redirect),
    .curPC(curPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_ready(inst_ready), .dbg_state_o(dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("curPC", curPC, m_pc);
    check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    check("imem_addr", imem_addr, m_addr);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("inst_pc", inst_pc, exp_q[0][63:32]);
      check("inst", inst, exp_q[0][31:0]);
      check("inst_err", {31'd0, inst_err}, 32'd0);
    end
  endtask

  // Applies one cycle of inputs and advances the model to the state after the next rising edge.
  task automatic drive_and_model(input bit ack, input bit rdy, input bit redir, input logic [31:0] npc);
    bit acked;
    imem_ack   = ack;
    inst_ready = rdy;
    redirect   = redir;
    nextPC     = npc;
    imem_rdata = ack ? mem_word(m_addr) : $urandom;
    acked = m_req && ack;
    if (redir) begin
      exp_q.delete();
      m_pc = npc & 32'hFFFF_FFFC;
      if (!m_req || acked) begin
        m_req     = 1'b1;
        m_addr    = m_pc;
        m_discard = 1'b0;
      end else begin
        m_discard = 1'b1;
      end
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (acked) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_addr    = m_pc;
        end else begin
          exp_q.push_back({m_addr, imem_rdata});
          m_pc = m_pc + 32'd4;
          if (exp_q.size() < 2) m_addr = m_pc;
          else                  m_req = 1'b0;
        end
      end else if (!m_req && exp_q.size() < 2) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic step(input bit ack, input bit rdy, input bit redir, input logic [31:0] npc);
    @(negedge CLK);
    compare_outputs();
    drive_and_model(ack, rdy, redir, npc);
  endtask

  // Asserts reset between clock edges, checks reset values immediately, then releases it.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    Reset    = 1'b0;
    imem_ack = 1'b1;
    redirect = 1'b0;
    #1;
    check("rst_curPC", curPC, 32'h0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_err", {31'd0, inst_err}, 32'd0);
    exp_q.delete();
    m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_discard = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    drive_and_model(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] npc;
    do_reset();

    // Zero-wait memory with decode always ready: back-to-back fetches 0,4,8,C,...
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // Decode stalls: FIFO fills, request drops, resumes after the first pop.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // Slow memory: request held for three wait cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    // Redirect while a request waits: the old response is discarded.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0400);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // Redirect coinciding with an ack, and a redirect near the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0800);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    // Reset in the middle of an outstanding request.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect coinciding with an ack: single error entry, no further requests.
    @(negedge CLK);
    compare_outputs();
    imem_ack   = 1'b1;
    imem_rdata = mem_word(m_addr);
    inst_ready = 1'b0;
    redirect   = 1'b1;
    nextPC     = 32'h0000_0102;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      redirect = 1'b0;
      imem_ack = 1'b0;
      check("align_req", {31'd0, imem_req}, 32'd0);
      check("align_valid", {31'd0, inst_valid}, 32'd1);
      check("align_pc", inst_pc, 32'h0000_0102);
      check("align_inst", inst, 32'h0);
      check("align_err", {31'd0, inst_err}, 32'd1);
      check("align_curPC", curPC, 32'h0000_0102);
    end
    do_reset();
`endif

    for (int i = 0; i < 4000; i++) begin
      npc = $urandom;
      if ($urandom_range(0, 3) == 0) npc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
`ifdef FETCH_ALIGN_CHECK_EN
      npc = npc & 32'hFFFF_FFFC;
`endif
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < 5, npc);
      end
    end

    @(negedge CLK);
    compare_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS32 core, directly downstream of the next-PC logic. It owns the PC register (`curPC`) that the next-PC logic reads, and issues word requests to instruction memory over a req/ack handshake. Fetched words are buffered with their PC in a 2-entry FIFO for decode. Redirect targets (jumps, branches, `jr`) arrive from the next-PC logic and flush the buffer.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `nextPC` in 32: redirect target from the next-PC logic.
- `redirect` in 1: `nextPC` is a non-sequential target; take it and flush.
- `curPC` out 32: address of the next fetch request; feeds the next-PC logic.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out 32: request address; stable while `imem_req`=1.
- `imem_ack` in 1: `imem_rdata` valid and request complete this cycle.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: FIFO head is valid.
- `inst` out 32: FIFO-head instruction.
- `inst_pc` out 32: FIFO-head PC.
- `inst_err` out 1: FIFO-head fetch error (see Configuration).
- `inst_ready` in 1: decode consumes the head when `inst_valid`=1.

## Operation
- **FIFO**
  - 2 entries of {pc, inst, err}.
  - Pop when `inst_valid` and `inst_ready` are both 1.
  - Push on an accepted ack.
  - A simultaneous push and pop when full is legal; the count is unchanged.
- **Free-slot rule:** a new request may start only if FIFO count plus in-flight requests is below 2. At most one request is outstanding.
- **FSM states**
  - IDLE: `imem_req`=0.
    - IDLE→REQ when a slot is free: `imem_addr`<=`curPC`.
  - REQ: `imem_req`=1.
    - On `imem_ack`: push {`imem_addr`, `imem_rdata`, 0}; `curPC`<=`curPC`+4 (32-bit wrap, 32'hFFFF_FFFC→0).
    - After the push, if a slot is still free (counting the pop in this cycle): stay in REQ with `imem_addr`<=new `curPC`; otherwise go to IDLE.
  - DROP: `imem_req`=1 at the old `imem_addr`.
    - On `imem_ack`: discard the data, then go to REQ at `curPC`.
- **Redirect** (highest priority, every state)
  - `curPC`<=`nextPC`; FIFO flushed, including any same-cycle push or pop.
  - IDLE→REQ at target.
  - REQ without ack→DROP.
  - REQ with ack→REQ at target; the acked data is dropped.
  - DROP stays DROP with the target updated; DROP with ack→REQ at target.
- `imem_addr` and `imem_req` never change while a request is outstanding without an ack.

## Timing
- **Reset** (asynchronous, any cycle, including mid-request):
  - `curPC`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `imem_req`=0, FSM=IDLE, FIFO empty.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_err`=0.
  - Any outstanding memory response is ignored after reset.
- **First request:** `imem_req`=1 in the first cycle after the first rising edge with `Reset`=1.
- **Latency:** ack in cycle N → `inst_valid`=1 in N+1.
- **Throughput:** one instruction per cycle with zero-wait memory, provided decode pops every cycle.
- **Redirect at edge N:** request at target is visible in N+1, or after the pending ack if in DROP.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `nextPC[1:0]`≠0 issues no memory request.
  - Instead it pushes {`nextPC`, 32'h0000_0000, err=1} once.
  - FSM then parks in IDLE until the next redirect.
- Undefined: `nextPC[1:0]` is forced to 2'b00 on redirect; `inst_err` is constant 0.

## Test plan
- **Reset, ack every cycle, `inst_ready`=1:** addresses 0,4,8,C on consecutive cycles; `inst_pc` follows one cycle later; `inst` equals the memory words.
- **`inst_ready`=0 for 5 cycles:** FIFO holds PCs 0 and 4; `imem_req` drops to 0; no request for PC 8 until the first pop.
- **Ack delayed 3 cycles:** `imem_addr`=0x10 and `imem_req`=1 held stable across all wait cycles.
- **Redirect to 0x400 while a request to 0x20 waits:** 0x20 data is discarded on its ack; the next request is 0x400; the FIFO is empty after the redirect.
- **Reset asserted mid-REQ:** all outputs reach reset values immediately; the next request after release is at `RESET_PC`.
- **`FETCH_ALIGN_CHECK_EN` with redirect to 0x102:** no request issued; `inst_valid`=1, `inst_pc`=0x102, `inst`=0, `inst_err`=1.
